// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the PC sequencer slice.
//               branch_t    - 3-bit branch class from the decoder
//               seq_state_t - sequencer FSM states
//               fault_t     - fault code reported when the sequencer halts
//               INSTR_BYTES - size of one instruction in bytes
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_RSVD = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BNE  = 3'b101,
    BR_BLT  = 3'b110,
    BR_BGE  = 3'b111
  } branch_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10
  } fault_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational branch decision and next-PC computation.
//   branch  in  3   branch class (see cpu_pkg::branch_t)
//   zero    in  1   ALU result == 0
//   less    in  1   ALU less-than
//   pc      in  32  PC of the executing instruction
//   rs1     in  32  jalr base register
//   imm     in  32  sign-extended immediate
//   taken   out 1   control transfer happens
//   next_pc out 32  address of the next instruction
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [2:0]  branch,
  input  logic        zero,
  input  logic        less,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  output logic        taken,
  output logic [31:0] next_pc
);

  branch_t     w_br;
  logic [31:0] w_seq_pc;
  logic [31:0] w_rel_pc;
  logic [31:0] w_jalr_sum;

  assign w_br = branch_t'(branch);

  // All sums wrap naturally at 32 bits.
  assign w_seq_pc   = pc + 32'(INSTR_BYTES);
  assign w_rel_pc   = pc + imm;
  assign w_jalr_sum = rs1 + imm;

  // The reserved encoding behaves like "no branch".
  always_comb begin
    taken = 1'b0;
    case (w_br)
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_BEQ:          taken = zero;
      BR_BNE:          taken = ~zero;
      BR_BLT:          taken = less;
      BR_BGE:          taken = ~less;
      default:         taken = 1'b0;
    endcase
  end

  // jalr drops bit 0 of the target; bit 1 survives and is caught upstream
  // as a misaligned target.
  always_comb begin
    next_pc = w_seq_pc;
    if (taken) begin
      if (w_br == BR_JALR) begin
        next_pc = {w_jalr_sum[31:1], 1'b0};
      end else begin
        next_pc = w_rel_pc;
      end
    end
  end

endmodule : branch_resolve
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute sequencer. Requests an instruction at pc,
//               holds it for the datapath until exec_done, then advances pc
//               to the resolved next PC and counts the retirement. Halts on
//               halt_req, misaligned target or fetch timeout.
//   clk          in  1   clock, rising edge
//   rst_n        in  1   asynchronous active-low reset
//   imem_req     out 1   fetch request (FETCH state)
//   imem_addr    out 32  fetch address (= pc)
//   imem_ready   in  1   imem_rdata valid this cycle
//   imem_rdata   in  32  fetched instruction
//   instr        out 32  registered instruction to the datapath
//   instr_valid  out 1   instr is executing (EXEC state)
//   branch       in  3   branch class
//   zero, less   in  1   ALU flags
//   rs1, imm     in  32  jalr base / sign-extended immediate
//   exec_done    in  1   datapath finished the current instruction
//   halt_req     in  1   halt after this instruction (sampled with exec_done)
//   pc           out 32  current PC
//   retire_cnt   out 32  retired-instruction count
//   halted       out 1   in HALT state
//   fault        out 2   00 none, 01 misaligned target, 10 fetch timeout
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic [2:0]  branch,
  input  logic        zero,
  input  logic        less,
  input  logic [31:0] rs1,
  input  logic [31:0] imm,
  input  logic        exec_done,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] retire_cnt,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam int unsigned c_WAIT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(IMEM_TIMEOUT - 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [31:0]         r_pc;
  logic [31:0]         r_retire_cnt;
  logic [31:0]         r_instr;
  fault_t              r_fault;

  logic                w_taken;
  logic [31:0]         w_next_pc;
  logic                w_capture;
  logic                w_retire;
  logic                w_misalign;
  logic                w_timeout;

  branch_resolve u_branch_resolve (
    .branch  (branch),
    .zero    (zero),
    .less    (less),
    .pc      (r_pc),
    .rs1     (rs1),
    .imm     (imm),
    .taken   (w_taken),
    .next_pc (w_next_pc)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes. Inputs are only looked at in the state
  // that owns them, so stray strobes elsewhere fall through untouched.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_retire     = 1'b0;
    w_misalign   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          w_capture    = 1'b1;
          w_state_next = ST_EXEC;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_retire = 1'b1;
          // pc is always word aligned, so only a redirect can misalign.
          w_misalign = w_taken && (w_next_pc[1:0] != 2'b00);
          if (w_misalign || halt_req) begin
            w_state_next = ST_HALT;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt   <= '0;
      r_pc         <= RESET_PC;
      r_retire_cnt <= 32'd0;
      r_instr      <= 32'd0;
      r_fault      <= FAULT_NONE;
    end else begin
      // Counts FETCH cycles; zero on every entry into FETCH.
      if (r_state == ST_FETCH) begin
        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_capture) begin
        r_instr <= imem_rdata;
      end

      // A misaligned target still retires, but pc keeps the faulting
      // instruction's address for post-mortem.
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
        if (!w_misalign) begin
          r_pc <= w_next_pc;
        end
      end

      if (w_misalign) begin
        r_fault <= FAULT_MISALIGN;
      end else if (w_timeout) begin
        r_fault <= FAULT_TIMEOUT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or pure state decode only
  // --------------------------------------------------------------------------
  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_EXEC);
  assign halted      = (r_state == ST_HALT);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign retire_cnt  = r_retire_cnt;
  assign instr       = r_instr;
  assign fault       = r_fault;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer with a behavioural
//               model of pc / retire count / halt / fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          IMEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  branch;
  logic        zero;
  logic        less;
  logic [31:0] rs1;
  logic [31:0] imm;
  logic        exec_done;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] retire_cnt;
  logic        halted;
  logic [1:0]  fault;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  logic        m_halted;
  logic [1:0]  m_fault;

  pc_sequencer #(
    .RESET_PC     (RESET_PC),
    .IMEM_TIMEOUT (IMEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .branch      (branch),
    .zero        (zero),
    .less        (less),
    .rs1         (rs1),
    .imm         (imm),
    .exec_done   (exec_done),
    .halt_req    (halt_req),
    .pc          (pc),
    .retire_cnt  (retire_cnt),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural next PC from the branch rules.
  function automatic logic [31:0] ref_next(input logic [2:0] br, input logic z, input logic l,
                                           input logic [31:0] p, input logic [31:0] r,
                                           input logic [31:0] i);
    logic take;
    if (br == 3'd2) return (r + i) & 32'hFFFF_FFFE;
    take = (br == 3'd1) || (br == 3'd4 && z) || (br == 3'd5 && !z) ||
           (br == 3'd6 && l) || (br == 3'd7 && !l);
    return take ? p + i : p + 32'd4;
  endfunction

  task automatic drive_idle();
    imem_ready = 1'b0; imem_rdata = 32'd0; branch = 3'd0; zero = 1'b0; less = 1'b0;
    rs1 = 32'd0; imm = 32'd0; exec_done = 1'b0; halt_req = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released (IDLE cycle).
  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = RESET_PC; m_retire = 32'd0; m_halted = 1'b0; m_fault = 2'b00;
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_fetch: imem_req=%b after %0d cycles, required 1", imem_req, n);
    end
  endtask

  // Fetch one instruction after fdly wait cycles, execute it for edly extra
  // cycles, then retire it and advance the model.
  task automatic run_instr(input logic [31:0] rdata, input int fdly, input logic [2:0] br,
                           input logic z, input logic l, input logic [31:0] r,
                           input logic [31:0] i, input int edly, input logic h);
    bit ok;
    logic [31:0] nxt;
    wait_fetch(ok);
    if (!ok) return;
    repeat (fdly) @(negedge clk);
    imem_ready = 1'b1; imem_rdata = rdata;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = $urandom;
    branch = br; zero = z; less = l; rs1 = r; imm = i;
    repeat (edly) @(negedge clk);
    exec_done = 1'b1; halt_req = h;
    @(negedge clk);
    exec_done = 1'b0; halt_req = 1'b0;
    nxt = ref_next(br, z, l, m_pc, r, i);
    m_retire = m_retire + 32'd1;
    if (nxt[1:0] != 2'b00) begin
      m_halted = 1'b1; m_fault = 2'b01;
    end else begin
      m_pc = nxt;
      if (h) begin m_halted = 1'b1; m_fault = 2'b00; end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== RESET_PC || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_pc_cnt: pc=%h cnt=%h, required %h 0", pc, retire_cnt, RESET_PC);
    end
    checks++;
    if ({instr, instr_valid, imem_req, halted, fault} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: instr=%h valid=%b req=%b halted=%b fault=%b, required all 0",
               instr, instr_valid, imem_req, halted, fault);
    end
    rst_n = 1'b1;
    m_pc = RESET_PC; m_retire = 32'd0; m_halted = 1'b0; m_fault = 2'b00;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_cycle: imem_req=%b, required 0", imem_req);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_fetch: req=%b addr=%h, required 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    bit ok;
    wait_fetch(ok);
    @(negedge clk);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_exec: instr=%h valid=%b req=%b, required 00000013 1 0",
               instr, instr_valid, imem_req);
    end
    branch = 3'd0; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    m_pc = 32'd4; m_retire = 32'd1;
    checks++;
    if (pc !== 32'd4 || retire_cnt !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'd4) begin
      errors++;
      $display("FAIL basic_retire: pc=%h cnt=%0d req=%b addr=%h, required 4 1 1 4",
               pc, retire_cnt, imem_req, imem_addr);
    end
  endtask

  task automatic test_cond_branch();
    run_instr($urandom, 0, 3'd1, 1'b0, 1'b0, 32'd0, 32'h100 - m_pc, 0, 1'b0);
    run_instr($urandom, 1, 3'd4, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF8, 1, 1'b0);
    checks++;
    if (pc !== 32'h0000_00F8 || pc !== m_pc) begin
      errors++;
      $display("FAIL beq_taken: pc=%h, required 000000f8", pc);
    end
    run_instr($urandom, 0, 3'd1, 1'b0, 1'b0, 32'd0, 32'd8, 0, 1'b0);
    run_instr($urandom, 2, 3'd4, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFF8, 0, 1'b0);
    checks++;
    if (pc !== 32'h0000_0104 || pc !== m_pc) begin
      errors++;
      $display("FAIL beq_not_taken: pc=%h, required 00000104", pc);
    end
    checks++;
    if (retire_cnt !== m_retire) begin
      errors++;
      $display("FAIL cond_retire: cnt=%0d, required %0d", retire_cnt, m_retire);
    end
  endtask

  task automatic test_exec_hold();
    bit ok;
    logic [31:0] word;
    int n;
    word = $urandom;
    n = $urandom_range(3, 8);
    wait_fetch(ok);
    imem_ready = 1'b1; imem_rdata = word;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      branch = 3'($urandom); zero = 1'($urandom); less = 1'($urandom);
      rs1 = $urandom; imm = $urandom; imem_ready = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (instr !== word || instr_valid !== 1'b1 || pc !== m_pc) begin
        errors++;
        $display("FAIL exec_hold[%0d]: instr=%h valid=%b pc=%h, required %h 1 %h",
                 k, instr, instr_valid, pc, word, m_pc);
      end
    end
    imem_ready = 1'b0; branch = 3'd0; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    m_pc = m_pc + 32'd4; m_retire = m_retire + 32'd1;
    // Stray exec_done/halt_req during FETCH must not retire or halt.
    exec_done = 1'b1; halt_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || halted !== 1'b0 || pc !== m_pc || retire_cnt !== m_retire) begin
        errors++;
        $display("FAIL stray_in_fetch[%0d]: req=%b halted=%b pc=%h cnt=%0d, required 1 0 %h %0d",
                 k, imem_req, halted, pc, retire_cnt, m_pc, m_retire);
      end
    end
    exec_done = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  br;
    logic [31:0] r, i;
    for (int k = 0; k < 40; k++) begin
      br = 3'($urandom_range(0, 7));
      r  = $urandom;
      i  = $urandom;
      if (br == 3'd2) begin
        if ((((r + i) & 32'hFFFF_FFFE) & 32'd2) != 32'd0) r = r ^ 32'd2;
      end else begin
        i = i & 32'hFFFF_FFFC;
      end
      run_instr($urandom, $urandom_range(0, 5), br, 1'($urandom), 1'($urandom), r, i,
                $urandom_range(0, 3), 1'b0);
      checks++;
      if (pc !== m_pc || retire_cnt !== m_retire || halted !== 1'b0 ||
          imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL random[%0d] br=%0d: pc=%h cnt=%0d halted=%b req=%b addr=%h, required %h %0d 0 1 %h",
                 k, br, pc, retire_cnt, halted, imem_req, imem_addr, m_pc, m_retire, m_pc);
      end
    end
  endtask

  task automatic test_wrap_halt();
    run_instr($urandom, 0, 3'd1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC - m_pc, 0, 1'b0);
    run_instr($urandom, 0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    checks++;
    if (pc !== 32'd0 || pc !== m_pc) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h, required 00000000", pc);
    end
    run_instr($urandom, 1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 2, 1'b1);
    checks++;
    if (halted !== 1'b1 || fault !== 2'b00 || retire_cnt !== m_retire ||
        pc !== m_pc || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_req: halted=%b fault=%b cnt=%0d pc=%h req=%b, required 1 00 %0d %h 0",
               halted, fault, retire_cnt, pc, imem_req, m_retire, m_pc);
    end
    for (int k = 0; k < 6; k++) begin
      imem_ready = 1'($urandom); exec_done = 1'($urandom); halt_req = 1'($urandom);
      branch = 3'($urandom); imm = $urandom;
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          pc !== m_pc || retire_cnt !== m_retire || fault !== 2'b00) begin
        errors++;
        $display("FAIL halt_terminal[%0d]: halted=%b req=%b valid=%b pc=%h cnt=%0d fault=%b",
                 k, halted, imem_req, instr_valid, pc, retire_cnt, fault);
      end
    end
    drive_idle();
  endtask

  task automatic test_misalign();
    apply_reset();
    run_instr($urandom, 0, 3'd2, 1'b0, 1'b0, 32'h2001, 32'd2, 0, 1'b0);
    checks++;
    if (halted !== 1'b1 || fault !== 2'b01 || pc !== RESET_PC || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL jalr_misalign: halted=%b fault=%b pc=%h cnt=%0d, required 1 01 %h 1",
               halted, fault, pc, retire_cnt, RESET_PC);
    end
    apply_reset();
    run_instr($urandom, 0, 3'd2, 1'b0, 1'b0, 32'h2001, 32'd3, 0, 1'b0);
    checks++;
    if (pc !== 32'h0000_2004 || halted !== 1'b0 || fault !== 2'b00) begin
      errors++;
      $display("FAIL jalr_aligned: pc=%h halted=%b fault=%b, required 00002004 0 00",
               pc, halted, fault);
    end
    // Misaligned target wins over a simultaneous halt request.
    run_instr($urandom, 0, 3'd5, 1'b0, 1'b0, 32'd0, 32'd6, 0, 1'b1);
    checks++;
    if (halted !== 1'b1 || fault !== 2'b01 || pc !== 32'h0000_2004 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL misalign_priority: halted=%b fault=%b pc=%h cnt=%0d, required 1 01 00002004 2",
               halted, fault, pc, retire_cnt);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    apply_reset();
    wait_fetch(ok);
    repeat (IMEM_TIMEOUT - 1) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_last_cycle: req=%b halted=%b, required 1 0", imem_req, halted);
    end
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL ready_at_limit: valid=%b instr=%h, required 1 cafe0001", instr_valid, instr);
    end
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    wait_fetch(ok);
    repeat (IMEM_TIMEOUT) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || fault !== 2'b10 || imem_req !== 1'b0 || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL fetch_timeout: halted=%b fault=%b req=%b cnt=%0d, required 1 10 0 1",
               halted, fault, imem_req, retire_cnt);
    end
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (halted !== 1'b1 || fault !== 2'b10 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: halted=%b fault=%b valid=%b, required 1 10 0",
               halted, fault, instr_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    apply_reset();
    run_instr($urandom, 0, 3'd1, 1'b0, 1'b0, 32'd0, 32'h40, 0, 1'b0);
    wait_fetch(ok);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== 32'h40) begin
      errors++;
      $display("FAIL pre_reset_exec: valid=%b pc=%h, required 1 00000040", instr_valid, pc);
    end
    #2;
    rst_n = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || pc !== RESET_PC || instr !== 32'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b pc=%h instr=%h req=%b, required 0 %h 0 0",
               instr_valid, pc, instr, imem_req, RESET_PC);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stale_ready: instr=%h valid=%b req=%b, required 0 0 1",
               instr, instr_valid, imem_req);
    end
    imem_ready = 1'b0;
    m_pc = RESET_PC; m_retire = 32'd0; m_halted = 1'b0; m_fault = 2'b00;
    run_instr($urandom, 0, 3'd3, 1'b1, 1'b1, 32'd0, 32'h20, 0, 1'b0);
    checks++;
    if (pc !== m_pc || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL post_reset_run: pc=%h cnt=%0d, required %h 1", pc, retire_cnt, m_pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cond_branch();
    test_exec_hold();
    test_random();
    test_wrap_halt();
    test_misalign();
    test_timeout();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 16, the maximum fetch-wait cycles before a fault.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 Ports, as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  registered instruction to the datapath.
- instr_valid  out  1  instr is executing.
- branch  in  3  branch class: 000 none, 001 jal, 010 jalr, 011 reserved (treated as none), 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu.
- zero  in  1  ALU result == 0.
- less  in  1  ALU less-than.
- rs1  in  32  jalr base.
- imm  in  32  sign-extended immediate.
- exec_done  in  1  datapath finished the current instruction.
- halt_req  in  1  ebreak/ecall halt request, sampled with exec_done.
- pc  out  32  current PC.
- retire_cnt  out  32  retired-instruction count.
- halted  out  1  in HALT.
- fault  out  2  00 none, 01 misaligned target, 10 fetch timeout.

Function
REQ-005 States SHALL be IDLE, FETCH, EXEC and HALT; IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-006 FETCH SHALL assert imem_req with imem_addr=pc.
- On imem_ready: capture imem_rdata into instr and go to EXEC.
- Wait counter SHALL clear on FETCH entry.
REQ-007 If imem_ready has not arrived after IMEM_TIMEOUT FETCH cycles, SHALL go to HALT with fault=10.
REQ-008 EXEC SHALL hold instr_valid=1 and instr stable until exec_done=1, for any number of cycles.
REQ-009 On exec_done in EXEC, SHALL load pc with next_pc, increment retire_cnt by 1, and go to FETCH; next fetch request appears the following cycle.
REQ-010 Taken SHALL be decided as follows:
- Always taken for 001/010.
- 100 taken when zero=1; 101 taken when zero=0.
- 110 taken when less=1; 111 taken when less=0.
- Never taken for 000/011.
REQ-011 next_pc SHALL be computed as follows:
- jalr: (rs1+imm) with bit0 cleared.
- Other taken: pc+imm.
- Not taken: pc+4.
- All additions modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-012 If next_pc[1:0]!=00, SHALL go to HALT with fault=01.
- pc SHALL be left unchanged.
- retire_cnt SHALL still increment.
REQ-013 halt_req=1 with exec_done SHALL retire the instruction, update pc to next_pc, and go to HALT with fault=00.
- Misaligned next_pc takes priority, giving fault=01.
REQ-014 HALT SHALL be terminal until reset, with halted=1 and imem_req=0; inputs SHALL be ignored.
REQ-015 exec_done, halt_req and imem_ready outside their states SHALL be ignored.
REQ-016 retire_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-017 All outputs SHALL be registered or decoded only from state; no input-to-output combinational path.

Reset
REQ-018 Reset assertion SHALL take effect immediately, including mid-fetch and mid-exec. Reset values:
- state=IDLE, pc=RESET_PC, retire_cnt=0.
- instr=0, instr_valid=0, imem_req=0.
- halted=0, fault=00.
REQ-019 An in-flight imem_ready arriving during or after reset SHALL be discarded.

Structure
REQ-020 Shared package cpu_pkg SHALL hold:
- branch_t (3-bit branch enum);
- seq_state_t;
- fault_t;
- the INSTR_BYTES=4 constant.
REQ-021 Taken/target logic SHALL be a combinational sub-module branch_resolve (inputs branch, zero, less, pc, rs1, imm; outputs taken, next_pc).

Verification
REQ-022 Reset release with RESET_PC=0, imem_ready one cycle after request with rdata=32'h00000013, exec_done next cycle, branch=000 -> pc=4, retire_cnt=1, second request at addr 4.
REQ-023 pc=0x100, branch=100, zero=1, imm=-8 -> pc=0xF8; repeat with zero=0 -> pc=0x104.
REQ-024 branch=010, rs1=0x2001, imm=2 -> pc=0x2002, fault=01 branch: expect HALT, fault=01, pc unchanged; rs1=0x2001, imm=3 -> pc=0x2004.
REQ-025 imem_ready held low 16 cycles -> HALT, fault=10, imem_req=0, retire_cnt unchanged.
REQ-026 rst_n low in mid-EXEC with pc=0x40 -> same-cycle instr_valid=0, pc=RESET_PC; stale imem_ready ignored.
REQ-027 pc=0xFFFFFFFC, branch=000 -> pc=0; halt_req with exec_done -> halted=1, fault=00, count incremented.
